// File: rtl/gate_driver_spi_responder.sv
// gate_driver_spi_responder: SPI slave emulating a 3-phase gate driver chip.
// Models a 16-bit-frame register file, sticky fault status, the nFAULT pin and
// EN/wake timing. It is the far end of the gate_driver_unit SPI master and is
// used for FPGA loopback and HIL work without a real driver IC.
// Frame: bit15 R/nW (1 = read), bits14:11 address, bits10:0 data, MSB first.
// Optional feature macro: GD_SPI_FRAME_CHECK_EN (frame length checking).
// Ports:
//   sys_clk, reset_n            system clock, async active-low reset
//   enable_in                   emulated EN pin (async)
//   spi_nscs_in/sclk_in/sdi_in  SPI slave inputs (async)
//   spi_sdo_out                 SPI slave data out
//   nfault_out                  low while any status bit is set
//   status_0_in, status_1_in    sticky fault event inputs
//   ctrl_regs_out               {reg6,reg5,reg4,reg3,reg2}
//   reg_wr_valid/addr/data_out  committed-write notification
//   frame_error_out             sticky malformed-frame flag
module gate_driver_spi_responder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned WAKE_CYCLES  = 1000,
  parameter logic [10:0] CTRL_DEFAULT = 11'h000
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        enable_in,
  input  logic        spi_nscs_in,
  input  logic        spi_sclk_in,
  input  logic        spi_sdi_in,
  output logic        spi_sdo_out,
  output logic        nfault_out,
  input  logic [10:0] status_0_in,
  input  logic [10:0] status_1_in,
  output logic [54:0] ctrl_regs_out,
  output logic        reg_wr_valid_out,
  output logic [3:0]  reg_wr_addr_out,
  output logic [10:0] reg_wr_data_out,
  output logic        frame_error_out
);

  localparam int unsigned DW     = 11;
  localparam int unsigned AW     = 4;
  localparam int unsigned CW     = 5 * DW;
  localparam int unsigned SW     = SYNC_STAGES * 4;
  localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int unsigned BCW    = 5;
  // Sync reset pattern {en, nscs, sclk, sdi}: chip select idles high.
  localparam logic [3:0]    SYNC_RST      = 4'b0100;
  // CLR_FLT (reg2 bit0) is never stored.
  localparam logic [DW-1:0] CTRL2_DEFAULT = CTRL_DEFAULT & ~DW'(1);
  localparam logic [CW-1:0] CTRL_RST      = {{4{CTRL_DEFAULT}}, CTRL2_DEFAULT};

  typedef enum logic [2:0] {
    ST_SLEEP, ST_WAKE, ST_IDLE, ST_CMD, ST_DATA, ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sync_q, sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              nscs_prev_q, nscs_prev_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]     shreg_q, shreg_d;
  logic              rnw_q, rnw_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     out_sh_q, out_sh_d;
  logic              sdo_q, sdo_d;
  logic [CW-1:0]     ctrl_q, ctrl_d;
  logic [DW-1:0]     status0_q, status0_d;
  logic [DW-1:0]     status1_q, status1_d;
  logic              nfault_q, nfault_d;
  logic              wr_valid_q, wr_valid_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic              ferr_q, ferr_d;

  logic          en_s, nscs_s, sclk_s, sdi_s;
  logic          sclk_rise, sclk_fall, nscs_rise, nscs_fall;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] rd_data;
  logic          clr_flt;
  logic          len_ok;

  assign en_s      = sync_q[SW-1];
  assign nscs_s    = sync_q[SW-2];
  assign sclk_s    = sync_q[SW-3];
  assign sdi_s     = sync_q[SW-4];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign nscs_rise = nscs_s & ~nscs_prev_q;
  assign nscs_fall = ~nscs_s & nscs_prev_q;

  // Address as it stands once the 5th command bit is being sampled.
  assign cmd_addr  = {shreg_q[2:0], sdi_s};

`ifdef GD_SPI_FRAME_CHECK_EN
  assign len_ok = (bit_cnt_q == BCW'(16));
`else
  assign len_ok = 1'b1;
`endif

  // Read-data mux, snapshotted at the end of the command phase.
  always_comb begin
    rd_data = '0;
    case (cmd_addr)
      4'd0:    rd_data = status0_q;
      4'd1:    rd_data = status1_q;
      4'd2:    rd_data = ctrl_q[0*DW +: DW];
      4'd3:    rd_data = ctrl_q[1*DW +: DW];
      4'd4:    rd_data = ctrl_q[2*DW +: DW];
      4'd5:    rd_data = ctrl_q[3*DW +: DW];
      4'd6:    rd_data = ctrl_q[4*DW +: DW];
      default: rd_data = '0;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SW-5:0], enable_in, spi_nscs_in, spi_sclk_in, spi_sdi_in};
    sclk_prev_d = sclk_s;
    nscs_prev_d = nscs_s;
    wake_cnt_d  = wake_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    out_sh_d    = out_sh_q;
    sdo_d       = sdo_q;
    ctrl_d      = ctrl_q;
    status0_d   = status0_q;
    status1_d   = status1_q;
    nfault_d    = ~|{status0_q, status1_q};
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ferr_d      = ferr_q;
    clr_flt     = 1'b0;

    if (!en_s) begin
      // EN low: sleep, discard any frame, hold registers at their defaults.
      state_d   = ST_SLEEP;
      sdo_d     = 1'b1;
      ctrl_d    = CTRL_RST;
      status0_d = '0;
      status1_d = '0;
      ferr_d    = 1'b0;
    end else begin
      case (state_q)
        ST_SLEEP: begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
        ST_WAKE: begin
          if (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1)) state_d = ST_IDLE;
          else wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
        ST_IDLE: begin
          sdo_d = 1'b1;
          if (nscs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
          end
        end
        default: begin
          if (nscs_rise) begin
            state_d = ST_IDLE;
            sdo_d   = 1'b1;
`ifdef GD_SPI_FRAME_CHECK_EN
            if (!len_ok) ferr_d = 1'b1;
`endif
            if (state_q == ST_DONE && !rnw_q && len_ok) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = shreg_q;
              case (addr_q)
                4'd2: begin
                  ctrl_d[0*DW +: DW] = {shreg_q[DW-1:1], 1'b0};
                  clr_flt            = shreg_q[0];
                end
                4'd3:    ctrl_d[1*DW +: DW] = shreg_q;
                4'd4:    ctrl_d[2*DW +: DW] = shreg_q;
                4'd5:    ctrl_d[3*DW +: DW] = shreg_q;
                4'd6:    ctrl_d[4*DW +: DW] = shreg_q;
                default: ;
              endcase
`ifdef GD_SPI_FRAME_CHECK_EN
              if (clr_flt) ferr_d = 1'b0;
`endif
            end
          end else if (state_q == ST_CMD) begin
            if (sclk_fall) begin
              shreg_d   = {shreg_q[DW-2:0], sdi_s};
              bit_cnt_d = bit_cnt_q + BCW'(1);
              if (bit_cnt_q == BCW'(4)) begin
                rnw_d    = shreg_q[3];
                addr_d   = cmd_addr;
                out_sh_d = rd_data;
                state_d  = ST_DATA;
              end
            end
          end else if (state_q == ST_DATA) begin
            if (sclk_fall) begin
              shreg_d   = {shreg_q[DW-2:0], sdi_s};
              bit_cnt_d = bit_cnt_q + BCW'(1);
              if (bit_cnt_q == BCW'(15)) begin
                state_d = ST_DONE;
                sdo_d   = 1'b1;
              end
            end else if (sclk_rise) begin
              sdo_d    = out_sh_q[DW-1];
              out_sh_d = {out_sh_q[DW-2:0], 1'b0};
            end
          end else begin
            // DONE: extra clocks only feed the (saturating) length count.
            sdo_d = 1'b1;
            if (sclk_fall && bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      endcase
      // Sticky status; a fault asserted alongside CLR_FLT survives the clear.
      status0_d = (clr_flt ? '0 : status0_q) | status_0_in;
      status1_d = (clr_flt ? '0 : status1_q) | status_1_in;
    end
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SLEEP;
      sync_q      <= {SYNC_STAGES{SYNC_RST}};
      sclk_prev_q <= 1'b0;
      nscs_prev_q <= 1'b1;
      wake_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      out_sh_q    <= '0;
      sdo_q       <= 1'b1;
      ctrl_q      <= CTRL_RST;
      status0_q   <= '0;
      status1_q   <= '0;
      nfault_q    <= 1'b1;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_prev_d;
      nscs_prev_q <= nscs_prev_d;
      wake_cnt_q  <= wake_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      out_sh_q    <= out_sh_d;
      sdo_q       <= sdo_d;
      ctrl_q      <= ctrl_d;
      status0_q   <= status0_d;
      status1_q   <= status1_d;
      nfault_q    <= nfault_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ferr_q      <= ferr_d;
    end
  end

  assign spi_sdo_out      = sdo_q;
  assign nfault_out       = nfault_q;
  assign ctrl_regs_out    = ctrl_q;
  assign reg_wr_valid_out = wr_valid_q;
  assign reg_wr_addr_out  = wr_addr_q;
  assign reg_wr_data_out  = wr_data_q;
  assign frame_error_out  = ferr_q;

endmodule
